// File: rtl/mips_program_encoder.sv
// rtl/mips_program_encoder.sv - builds MIPS instruction words from fields and writes them
// sequentially into instruction memory through one registered write port.
module mips_program_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  finish,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            kind,
  input  logic [4:0]            rs,
  input  logic [4:0]            rt,
  input  logic [4:0]            rd,
  input  logic [4:0]            shamt,
  input  logic [5:0]            funct,
  input  logic [15:0]           imm16,
  input  logic [25:0]           target26,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  full,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int                    DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   LAST_COUNT = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_PTR   = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  err_q, err_d;
  logic                  mem_we_q, mem_we_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [31:0]           enc_word;
  logic                  accept;

  always_comb begin
    enc_word = 32'h0;
    case (kind)
      3'd0:    enc_word = {6'h00, rs, rt, rd, shamt, funct};
      3'd1:    enc_word = {6'h08, rs, rt, imm16};
      3'd2:    enc_word = {6'h0d, rs, rt, imm16};
      3'd3:    enc_word = {6'h0c, rs, rt, imm16};
      3'd4:    enc_word = {6'h04, rs, rt, imm16};
      3'd5:    enc_word = {6'h05, rs, rt, imm16};
      3'd6:    enc_word = {6'h02, target26};
      default: enc_word = 32'h0;
    endcase
  end

  // start takes priority over any offered word, so the handshake is suppressed while it is high
  assign in_ready = (state_q == S_LOAD) && !full_q && !start;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    full_d      = full_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (start) begin
      state_d  = S_LOAD;
      wr_ptr_d = BASE_PTR;
      count_d  = '0;
      full_d   = 1'b0;
      err_d    = 1'b0;
    end else if (state_q == S_LOAD) begin
      if (accept) begin
        if (kind == 3'd7) begin
          err_d = 1'b1;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_ptr_q;
          mem_wdata_d = enc_word;
          wr_ptr_d    = wr_ptr_q + 1'b1;
          count_d     = count_q + 1'b1;
          if (count_q == LAST_COUNT) begin
            full_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      if (finish) begin
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= BASE_PTR;
      count_q     <= '0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q == S_LOAD);
  assign done      = (state_q == S_DONE);
  assign full      = full_q;
  assign err       = err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_mips_program_encoder.sv
// tb/tb_mips_program_encoder.sv - bench for mips_program_encoder: encoding table, directed
// corner sequences and randomized traffic against a reference model on two parameterisations.
module tb_mips_program_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, finish = 1'b0, in_valid = 1'b0;
  logic [2:0]  kind = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [5:0]  funct = '0;
  logic [15:0] imm16 = '0;
  logic [25:0] target26 = '0;

  logic        a_ready, a_we, a_busy, a_done, a_full, a_err;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic [8:0]  a_count;
  logic        b_ready, b_we, b_busy, b_done, b_full, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  mips_program_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .reset(reset), .start(start), .finish(finish), .in_valid(in_valid),
    .in_ready(a_ready), .kind(kind), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm16(imm16), .target26(target26), .mem_we(a_we), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .busy(a_busy), .done(a_done), .full(a_full), .err(a_err),
    .count(a_count)
  );

  mips_program_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .finish(finish), .in_valid(in_valid),
    .in_ready(b_ready), .kind(kind), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm16(imm16), .target26(target26), .mem_we(b_we), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .busy(b_busy), .done(b_done), .full(b_full), .err(b_err),
    .count(b_count)
  );

  // Reference model: st 0=IDLE 1=LOAD 2=DONE, pointers kept as plain integers
  typedef struct {
    int          st;
    int          ptr;
    int          cnt;
    bit          full;
    bit          err;
    bit          we;
    int          addr;
    logic [31:0] wdata;
  } mdl_t;

  localparam mdl_t MDL_RST = '{st: 0, ptr: 0, cnt: 0, full: 0, err: 0, we: 0, addr: 0, wdata: 32'h0};
  mdl_t ma = MDL_RST;
  mdl_t mb = MDL_RST;

  function automatic logic [31:0] ref_enc();
    int op[7] = '{0, 8, 13, 12, 4, 5, 2};
    int k = int'(kind);
    if (k == 0)
      return 32'(rs) * 32'h200000 + 32'(rt) * 32'h10000 + 32'(rd) * 32'h800
             + 32'(shamt) * 32'h40 + 32'(funct);
    if (k == 6)
      return 32'(op[6]) * 32'h4000000 + 32'(target26);
    return 32'(op[k]) * 32'h4000000 + 32'(rs) * 32'h200000 + 32'(rt) * 32'h10000 + 32'(imm16);
  endfunction

  function automatic mdl_t step(mdl_t m, int depth, int base);
    mdl_t n = m;
    n.we = 0;
    if (start) begin
      n.st = 1; n.ptr = base; n.cnt = 0; n.full = 0; n.err = 0;
    end else if (m.st == 1) begin
      if (in_valid && !m.full) begin
        if (kind == 3'd7) n.err = 1;
        else begin
          n.we = 1; n.addr = m.ptr; n.wdata = ref_enc();
          n.ptr = (m.ptr + 1) % depth;
          n.cnt = m.cnt + 1;
          if (n.cnt == depth) begin n.full = 1; n.st = 2; end
        end
      end
      if (finish) n.st = 2;
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ma <= MDL_RST;
      mb <= MDL_RST;
    end else begin
      ma <= step(ma, 256, 0);
      mb <= step(mb, 4, 2);
    end
  end

  function automatic logic [79:0] pack(bit we, int addr, logic [31:0] wd, bit rdy, bit bsy,
                                       bit dn, bit fl, bit er, int cnt);
    return {3'b0, we, 16'(addr), wd, 3'b0, rdy, bsy, dn, fl, er, 16'(cnt)};
  endfunction

  task automatic chk(string nm, logic [79:0] got, logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_a", pack(a_we, int'(a_addr), a_wdata, a_ready, a_busy, a_done, a_full, a_err, int'(a_count)),
          pack(ma.we, ma.addr, ma.wdata, ma.st == 1 && !ma.full && !start, ma.st == 1, ma.st == 2,
               ma.full, ma.err, ma.cnt));
      chk("model_b", pack(b_we, int'(b_addr), b_wdata, b_ready, b_busy, b_done, b_full, b_err, int'(b_count)),
          pack(mb.we, mb.addr, mb.wdata, mb.st == 1 && !mb.full && !start, mb.st == 1, mb.st == 2,
               mb.full, mb.err, mb.cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(logic [2:0] k, logic [4:0] s, logic [4:0] t, logic [4:0] d, logic [4:0] sh,
                       logic [5:0] f, logic [15:0] im, logic [25:0] tg);
    kind = k; rs = s; rt = t; rd = d; shamt = sh; funct = f; imm16 = im; target26 = tg;
    in_valid = 1'b1;
  endtask

  task automatic begin_session();
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  k;
    logic [4:0]  s, t, d, sh;
    logic [5:0]  f;
    logic [15:0] im;
    logic [25:0] tg;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[7];
  int   nwr;
  int   exp_b_addr[4] = '{2, 3, 0, 1};

  initial begin
    vt[0] = '{3'd0, 5'd1, 5'd2, 5'd3, 5'd4, 6'h2a, 16'hffff, 26'h3ffffff, 32'h0022192a};
    vt[1] = '{3'd2, 5'd31, 5'd1, 5'd7, 5'd7, 6'h3f, 16'habcd, 26'h1234567, 32'h37e1abcd};
    vt[2] = '{3'd3, 5'd2, 5'd3, 5'd0, 5'd0, 6'h00, 16'h00ff, 26'h0, 32'h304300ff};
    vt[3] = '{3'd5, 5'd4, 5'd5, 5'd9, 5'd1, 6'h11, 16'h8000, 26'h0, 32'h14858000};
    vt[4] = '{3'd6, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3f, 16'hffff, 26'h3ffffff, 32'h0bffffff};
    vt[5] = '{3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0, 32'h20080005};
    vt[6] = '{3'd4, 5'd8, 5'd9, 5'd3, 5'd3, 6'h01, 16'hffff, 26'h0, 32'h1109ffff};

    #2;
    chk("reset_a", pack(a_we, int'(a_addr), a_wdata, a_ready, a_busy, a_done, a_full, a_err, int'(a_count)), 80'h0);
    chk("reset_b", pack(b_we, int'(b_addr), b_wdata, b_ready, b_busy, b_done, b_full, b_err, int'(b_count)), 80'h0);
    tick();
    reset = 1'b1;
    chk_en = 1;
    tick();

    // 1: single ADDI
    begin_session();
    offer(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0);
    tick();
    in_valid = 1'b0;
    chk("t1_write", {a_we, a_addr, a_wdata, a_count}, {1'b1, 8'd0, 32'h20080005, 9'd1});

    // 2: back-to-back R, BEQ, J
    begin_session();
    offer(3'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0, 26'h0);
    tick();
    chk("t2_r", {a_we, a_addr, a_wdata}, {1'b1, 8'd0, 32'h01095020});
    offer(3'd4, 5'd8, 5'd9, 5'd0, 5'd0, 6'h0, 16'hffff, 26'h0);
    tick();
    chk("t2_beq", {a_we, a_addr, a_wdata}, {1'b1, 8'd1, 32'h1109ffff});
    offer(3'd6, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0100000);
    tick();
    chk("t2_j", {a_we, a_addr, a_wdata}, {1'b1, 8'd2, 32'h08100000});
    in_valid = 1'b0;
    tick();
    chk("t2_idle_we", 80'(a_we), 80'h0);

    // 3: fill the 4-deep instance, wrapping from BASE_ADDR=2
    begin_session();
    nwr = 0;
    for (int i = 0; i < 6; i++) begin
      offer(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'(i), 26'h0);
      tick();
      if (b_we) begin
        if (nwr < 4) chk("t3_addr", 80'(b_addr), 80'(exp_b_addr[nwr]));
        nwr++;
      end
    end
    chk("t3_writes", 80'(nwr), 80'd4);
    chk("t3_flags", {b_full, b_done, b_ready, b_count}, {1'b1, 1'b1, 1'b0, 3'd4});
    in_valid = 1'b0;

    // 4: illegal kind between two ADDIs
    begin_session();
    offer(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0001, 26'h0);
    tick();
    chk("t4_first", {a_we, a_addr, a_wdata}, {1'b1, 8'd0, 32'h20080001});
    offer(3'd7, 5'd3, 5'd3, 5'd3, 5'd3, 6'h3, 16'h3333, 26'h0);
    tick();
    chk("t4_illegal", {a_we, a_err}, {1'b0, 1'b1});
    offer(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0002, 26'h0);
    tick();
    chk("t4_second", {a_we, a_addr, a_wdata}, {1'b1, 8'd1, 32'h20080002});
    in_valid = 1'b0;
    tick();
    chk("t4_count", {a_count, a_err}, {9'd2, 1'b1});

    // 5: asynchronous reset while a write is on the port
    begin_session();
    offer(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0003, 26'h0);
    tick();
    offer(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0);
    tick();
    reset = 1'b0;
    #1;
    chk("t5_reset", pack(a_we, int'(a_addr), a_wdata, a_ready, a_busy, a_done, a_full, a_err, int'(a_count)), 80'h0);
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    begin_session();
    offer(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0);
    tick();
    in_valid = 1'b0;
    chk("t5_restart", {a_we, a_addr, a_wdata}, {1'b1, 8'd0, 32'h20080005});

    // 6: finish together with an accept, then restart
    begin_session();
    offer(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0011, 26'h0);
    tick();
    offer(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);
    tick();
    offer(3'd1, 5'd0, 5'd9, 5'd0, 5'd0, 6'h0, 16'h0033, 26'h0);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    in_valid = 1'b0;
    chk("t6_finish", {a_we, a_addr, a_wdata, a_done, a_err}, {1'b1, 8'd1, 32'h20090033, 1'b1, 1'b1});
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_restart", {a_count, a_err, a_busy}, {9'd0, 1'b0, 1'b1});
    offer(3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0044, 26'h0);
    tick();
    in_valid = 1'b0;
    chk("t6_base", {a_we, a_addr, a_wdata}, {1'b1, 8'd0, 32'h20080044});

    // encoding table
    begin_session();
    for (int i = 0; i < 7; i++) begin
      offer(vt[i].k, vt[i].s, vt[i].t, vt[i].d, vt[i].sh, vt[i].f, vt[i].im, vt[i].tg);
      tick();
      chk($sformatf("table_%0d", i), {a_we, a_wdata}, {1'b1, vt[i].exp});
    end
    in_valid = 1'b0;
    tick();

    // randomized traffic, checked each cycle against the model
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(99) != 0);
      start    = ($urandom_range(15) == 0);
      finish   = ($urandom_range(15) == 0);
      in_valid = ($urandom_range(3) != 0);
      kind     = 3'($urandom_range(7));
      rs       = 5'($urandom);
      rt       = 5'($urandom);
      rd       = 5'($urandom);
      shamt    = 5'($urandom);
      funct    = 6'($urandom);
      imm16    = 16'($urandom);
      target26 = 26'($urandom);
      tick();
    end
    reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
